// File: rtl/md_stall_ctrl.sv
// Stall/sequencing controller: freezes PC/FD/DX around multdiv ops and inserts load-use bubbles.
// Optional watchdog on the multdiv wait, enabled by defining MD_TIMEOUT_EN.
module md_stall_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    input  logic        md_resultRDY,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        pc_en,
    output logic        fd_en,
    output logic        dx_en,
    output logic        dx_bubble,
    output logic        xm_bubble,
    output logic        md_done,
    output logic        md_busy,
    output logic [31:0] md_ir_q,
    output logic [31:0] md_result_q,
    output logic        md_exc_q
);

    if (MD_TIMEOUT < 1 || MD_TIMEOUT >= (1 << CNT_W)) begin : g_cfg_err
        $error("md_stall_ctrl: MD_TIMEOUT must be in [1, 2**CNT_W)");
    end

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;

    logic [4:0] dx_op, fd_op, lw_dst, fd_a, fd_b;
    logic       dx_mul, dx_div, dx_lw, fd_a_vld, fd_b_vld, load_use, issue, wait_exit;
    logic       unused_fd_bits;

    assign unused_fd_bits = ^fd_ir[11:0];

    assign dx_op  = dx_ir[31:27];
    assign fd_op  = fd_ir[31:27];
    assign lw_dst = dx_ir[26:22];
    assign dx_mul = (dx_op == 5'b00000) && (dx_ir[6:2] == 5'b00110);
    assign dx_div = (dx_op == 5'b00000) && (dx_ir[6:2] == 5'b00111);
    assign dx_lw  = (dx_op == 5'b01000);

    // sw data operand is left out: the WM bypass already covers it
    always_comb begin
        fd_a     = fd_ir[21:17];
        fd_b     = fd_ir[16:12];
        fd_a_vld = 1'b0;
        fd_b_vld = 1'b0;
        case (fd_op)
            5'b00100: begin fd_a = fd_ir[26:22]; fd_a_vld = 1'b1; end
            5'b00000: begin fd_a_vld = 1'b1; fd_b_vld = 1'b1; end
            5'b00101, 5'b01000, 5'b00111: fd_a_vld = 1'b1;
            5'b00010, 5'b00110: begin fd_a_vld = 1'b1; fd_b = fd_ir[26:22]; fd_b_vld = 1'b1; end
            default: ;
        endcase
    end

    assign load_use = dx_lw && (lw_dst != 5'd0) &&
                      ((fd_a_vld && fd_a == lw_dst) || (fd_b_vld && fd_b == lw_dst));

    assign issue = (state == IDLE) && !reset && (dx_mul || dx_div);

`ifdef MD_TIMEOUT_EN
    logic timeout;
    assign timeout   = !md_resultRDY && (cnt == CNT_W'(MD_TIMEOUT - 1));
    assign wait_exit = md_resultRDY || timeout;
`else
    assign wait_exit = md_resultRDY;
`endif

    always_comb begin
        state_nxt = state;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        dx_en     = 1'b1;
        dx_bubble = 1'b0;
        xm_bubble = 1'b0;
        md_done   = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    ctrl_mult = dx_mul;
                    ctrl_div  = dx_div;
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    dx_en     = 1'b0;
                    xm_bubble = 1'b1;
                    state_nxt = WAIT;
                end else if (load_use) begin
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    dx_bubble = 1'b1;
                end
            end
            WAIT: begin
                pc_en     = 1'b0;
                fd_en     = 1'b0;
                dx_en     = 1'b0;
                xm_bubble = 1'b1;
                if (wait_exit) state_nxt = DONE;
            end
            DONE: begin
                md_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign md_busy = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            md_ir_q     <= '0;
            md_result_q <= '0;
            md_exc_q    <= 1'b0;
        end else if (issue) begin
            md_ir_q <= dx_ir;
            cnt     <= '0;
        end else if (state == WAIT) begin
            if (md_resultRDY) begin
                md_result_q <= md_result;
                md_exc_q    <= md_exception;
            end
`ifdef MD_TIMEOUT_EN
            else if (timeout) begin
                md_result_q <= '0;
                md_exc_q    <= 1'b1;
            end
`endif
            if (!(&cnt)) cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Directed bench for md_stall_ctrl: multdiv sequencing, load-use stalls, reset and watchdog.
module tb_md_stall_ctrl;

    localparam logic [31:0] MUL_3_1_2 = 32'h00C2_2018;
    localparam logic [31:0] DIV_4_1_2 = 32'h0102_201C;
    localparam logic [31:0] LW_5_1    = 32'h4142_0000;
    localparam logic [31:0] LW_0_1    = 32'h4002_0000;
    localparam logic [31:0] ADD_6_5_2 = 32'h018A_2000;
    localparam logic [31:0] ADD_6_2_5 = 32'h0184_5000;
    localparam logic [31:0] SW_5_1    = 32'h3942_0000;
    localparam logic [31:0] BNE_5_1   = 32'h1142_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fd_ir, dx_ir, md_result;
    logic        md_resultRDY, md_exception;
    logic        ctrl_mult, ctrl_div, pc_en, fd_en, dx_en, dx_bubble, xm_bubble;
    logic        md_done, md_busy, md_exc_q;
    logic [31:0] md_ir_q, md_result_q;

    int n_cmp = 0;
    int n_err = 0;

    md_stall_ctrl #(.MD_TIMEOUT(8), .CNT_W(6)) dut (
        .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir),
        .md_resultRDY(md_resultRDY), .md_exception(md_exception), .md_result(md_result),
        .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .pc_en(pc_en), .fd_en(fd_en),
        .dx_en(dx_en), .dx_bubble(dx_bubble), .xm_bubble(xm_bubble), .md_done(md_done),
        .md_busy(md_busy), .md_ir_q(md_ir_q), .md_result_q(md_result_q), .md_exc_q(md_exc_q)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_run(input string tag);
        chk({tag, "_en"}, {29'd0, pc_en, fd_en, dx_en}, 32'h7);
        chk({tag, "_bub"}, {30'd0, dx_bubble, xm_bubble}, 32'h0);
    endtask

    int frozen, pulses, waits;

    initial begin
        reset = 1'b1;
        fd_ir = '0; dx_ir = '0; md_result = '0; md_resultRDY = 1'b0; md_exception = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk_run("rst");
        chk("rst_pulse", {30'd0, ctrl_mult, ctrl_div}, 32'h0);
        chk("rst_done_busy", {30'd0, md_done, md_busy}, 32'h0);
        chk("rst_ir_q", md_ir_q, 32'h0);
        chk("rst_res_q", md_result_q, 32'h0);
        chk("rst_exc_q", md_exc_q, 32'h0);

        // mul issue, result after 4 WAIT cycles
        dx_ir = MUL_3_1_2;
        #1;
        chk("mul_issue_pulse", {30'd0, ctrl_mult, ctrl_div}, 32'h2);
        chk("mul_issue_busy", md_busy, 0);
        frozen = 0; pulses = 0;
        for (int i = 0; i < 5; i++) begin
            md_resultRDY = (i == 4);
            md_result    = (i == 4) ? 32'h42 : 32'hDEAD_BEEF;
            #1;
            if (!pc_en && !fd_en && !dx_en && xm_bubble) frozen++;
            pulses += int'(ctrl_mult);
            tick();
        end
        md_resultRDY = 1'b0;
        dx_ir = DIV_4_1_2;
        #1;
        chk("mul_frozen", frozen, 5);
        chk("mul_pulses", pulses, 1);
        chk("mul_done", md_done, 1);
        chk("mul_busy", md_busy, 1);
        chk("mul_res_q", md_result_q, 32'h42);
        chk("mul_ir_q", md_ir_q, MUL_3_1_2);
        chk_run("mul_done");
        chk("done_no_pulse", {30'd0, ctrl_mult, ctrl_div}, 32'h0);

        // div issued one cycle after mul DONE, finishes with an exception
        tick();
        chk("b2b_div_pulse", {30'd0, ctrl_mult, ctrl_div}, 32'h1);
        chk("b2b_busy", md_busy, 0);
        tick();
        md_resultRDY = 1'b1; md_exception = 1'b1; md_result = 32'h7;
        tick();
        md_resultRDY = 1'b0; md_exception = 1'b0;
        #1;
        chk("div_done", md_done, 1);
        chk("div_exc_q", md_exc_q, 1);
        chk("div_res_q", md_result_q, 32'h7);
        chk("div_ir_q", md_ir_q, DIV_4_1_2);
        dx_ir = '0;
        tick();
        chk("idle_after_div", {30'd0, md_done, md_busy}, 32'h0);

        // load-use cases
        dx_ir = LW_5_1; fd_ir = ADD_6_5_2;
        #1;
        chk("lu_en", {29'd0, pc_en, fd_en, dx_en}, 32'h1);
        chk("lu_bub", {30'd0, dx_bubble, xm_bubble}, 32'h2);
        tick();
        dx_ir = '0;
        #1;
        chk_run("lu_clear");
        dx_ir = LW_0_1;
        #1;
        chk_run("lu_r0");
        dx_ir = LW_5_1; fd_ir = SW_5_1;
        #1;
        chk_run("lu_sw");
        fd_ir = ADD_6_2_5;
        #1;
        chk("lu_opb", {31'd0, dx_bubble}, 32'h1);
        fd_ir = BNE_5_1;
        #1;
        chk("lu_bne", {31'd0, dx_bubble}, 32'h1);
        dx_ir = '0; fd_ir = '0;
        tick();

`ifdef MD_TIMEOUT_EN
        dx_ir = MUL_3_1_2;
        tick();
        waits = 0;
        while (!md_done && waits < 20) begin
            waits++;
            tick();
        end
        chk("to_done", md_done, 1);
        chk("to_wait_cycles", waits, 8);
        chk("to_exc_q", md_exc_q, 1);
        chk("to_res_q", md_result_q, 32'h0);
`else
        dx_ir = MUL_3_1_2;
        tick();
        for (int i = 0; i < 70; i++) tick();
        chk("hold_busy", md_busy, 1);
        chk("hold_done", md_done, 0);
        md_resultRDY = 1'b1; md_result = 32'h55;
        tick();
        md_resultRDY = 1'b0;
        chk("hold_done_late", md_done, 1);
        chk("hold_res_q", md_result_q, 32'h55);
        chk("hold_exc_q", md_exc_q, 0);
`endif
        dx_ir = '0;
        tick();

        // reset during WAIT
        dx_ir = MUL_3_1_2;
        tick();
        chk("rw_busy_pre", md_busy, 1);
        reset = 1'b1;
        #1;
        chk_run("rw");
        chk("rw_busy", md_busy, 0);
        chk("rw_no_pulse", {30'd0, ctrl_mult, ctrl_div}, 32'h0);
        dx_ir = '0;
        tick();
        reset = 1'b0;
        md_resultRDY = 1'b1; md_result = 32'h99; md_exception = 1'b1;
        tick();
        md_resultRDY = 1'b0; md_exception = 1'b0;
        #1;
        chk("rw_late_done", {30'd0, md_done, md_busy}, 32'h0);
        chk("rw_late_res_q", md_result_q, 32'h0);
        chk("rw_late_exc_q", md_exc_q, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
